pll_reset_ce_gen: RTL and testbench
===================================

Name: pll_reset_ce_gen

Overview:
- Sits directly downstream of the system PLL.
- Runs on the 48 MHz PLL output and consumes the PLL's raw `locked` flag.
- Synchronises `locked`, holds the core in reset until lock has been stable for a programmable time, then releases reset.
- While running, generates the core's clock enables: an integer-divided pixel enable and a fractionally-divided CPU enable.

Parameters:
- SYNC_STAGES, 2, number of flops in the `pll_locked` synchroniser (min 2).
- HOLD_CYCLES, 4800, cycles `locked` must stay stable before reset release (100 us at 48 MHz).
- DIV_PIX, 8, integer divider for `ce_pix` (48 MHz / 8 = 6 MHz); min 2.
- CE_NUM, 8, numerator of the fractional CPU enable ratio.
- CE_DEN, 125, denominator of the fractional CPU enable ratio (48 MHz * 8 / 125 = 3.072 MHz); requires 1 <= CE_NUM <= CE_DEN.

Ports:
- clk  in  1  48 MHz PLL output clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  raw PLL `locked`, asynchronous to clk.
- core_reset  out  1  reset to the core, active high.
- ready  out  1  high while in RUN.
- ce_pix  out  1  one-cycle pixel clock enable pulse.
- ce_cpu  out  1  one-cycle CPU clock enable pulse.

Behaviour:
- Reset (rst=1 at an edge):
  - synchroniser cleared, state=WAIT_LOCK, hold counter=0, pix counter=0, accumulator=0.
  - outputs: core_reset=1, ready=0, ce_pix=0, ce_cpu=0.
- locked_s: `pll_locked` through SYNC_STAGES flops; the only use of `pll_locked`.
- State machine:
  - WAIT_LOCK:
    - locked_s=1 -> HOLD, hold counter cleared to 0.
  - HOLD:
    - locked_s=0 -> WAIT_LOCK.
    - else hold counter increments.
    - counter==HOLD_CYCLES-1 with locked_s=1 -> RUN.
    - locked_s drop takes priority over the terminal count.
  - RUN:
    - locked_s=0 -> WAIT_LOCK.
- Outputs are registers updated on the same edge as the state:
  - core_reset=0 and ready=1 exactly in cycles where state==RUN; otherwise core_reset=1, ready=0.
- Latency: `core_reset` falls SYNC_STAGES+1+HOLD_CYCLES edges after the `pll_locked` rise is first sampled.
- Lock loss in RUN: core_reset=1 and ce_* forced 0 SYNC_STAGES+1 edges after `pll_locked` falls. A glitch shorter than one clk period is not guaranteed to be filtered.
- Pixel enable:
  - pix counter and accumulator are zeroed on every entry to RUN and held at 0 outside RUN.
  - pix counter counts 0..DIV_PIX-1 and wraps.
  - ce_pix high in RUN cycles DIV_PIX, 2*DIV_PIX, ... (RUN entry cycle = cycle 1); exact period DIV_PIX.
- CPU enable:
  - each RUN cycle, sum = acc + CE_NUM.
  - if sum >= CE_DEN: acc = sum - CE_DEN and ce_cpu=1; else acc = sum and ce_cpu=0.
  - accumulator width is clog2(CE_DEN)+1 bits, with no overflow for any legal parameters.
  - any CE_DEN consecutive RUN cycles contain exactly CE_NUM pulses.
  - first pulse in RUN cycle ceil(CE_DEN/CE_NUM).
  - CE_NUM==CE_DEN gives ce_cpu=1 every RUN cycle.
- ce_pix and ce_cpu may coincide; they are independent.
- rst asserted mid-RUN: all outputs return to reset values at that edge; the full HOLD sequence is required again.

Optional Feature:
- Macro: PLL_LOCK_LOSS_CNT_EN.
- Defined:
  - adds output `lock_loss_cnt`, 8 bits.
  - increments on every RUN->WAIT_LOCK transition, saturates at 255.
  - cleared only by rst; HOLD->WAIT_LOCK aborts are not counted.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Use SYNC_STAGES=2, HOLD_CYCLES=16, DIV_PIX=8, CE_NUM=8, CE_DEN=125 unless noted.
- Release: rst for 4 cycles, pll_locked rises -> core_reset stays 1 for 18 edges, falls at edge 19; ready rises the same edge.
- Hold abort: pll_locked high 10 cycles, low 3 cycles, then high -> no reset release until 19 edges after the second rise.
- Pixel enable in RUN -> ce_pix first high in RUN cycle 8, then exactly every 8 cycles; 1000 cycles give 125 pulses.
- CPU enable in RUN -> first ce_cpu in RUN cycle 16; every 125-cycle window has exactly 8 pulses. With CE_NUM=CE_DEN=5 -> ce_cpu constant 1.
- Lock loss: drop pll_locked in RUN -> core_reset=1, ready=0, ce_*=0 at edge 3. Restore -> re-release after 19 edges; ce_pix phase restarts at RUN cycle 8. With PLL_LOCK_LOSS_CNT_EN -> lock_loss_cnt=1; 300 losses give 255.
- rst mid-RUN, pll_locked held high -> outputs reset at that edge; after rst deasserts, core_reset falls 19 edges later.

Source files
------------

// File: rtl/pll_reset_ce_gen.sv
// PLL lock synchroniser, reset sequencer and clock-enable generator (integer pixel CE, fractional CPU CE).
// Optional lock-loss counter output is built when PLL_LOCK_LOSS_CNT_EN is defined.
module pll_reset_ce_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4800,
  parameter int DIV_PIX     = 8,
  parameter int CE_NUM      = 8,
  parameter int CE_DEN      = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       core_reset,
  output logic       ready,
  output logic       ce_pix,
`ifdef PLL_LOCK_LOSS_CNT_EN
  output logic [7:0] lock_loss_cnt,
`endif
  output logic       ce_cpu
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int PIX_W  = $clog2(DIV_PIX);
  localparam int ACC_W  = $clog2(CE_DEN) + 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(DIV_PIX - 1);
  localparam logic [PIX_W-1:0]  PIX_PRE   = PIX_W'(DIV_PIX - 2);
  localparam logic [ACC_W-1:0]  ACC_NUM   = ACC_W'(CE_NUM);
  localparam logic [ACC_W-1:0]  ACC_DEN   = ACC_W'(CE_DEN);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic [HOLD_W-1:0]      hold_cnt_r;
  logic [PIX_W-1:0]       pix_cnt_r;
  logic [ACC_W-1:0]       acc_r;

  logic                   locked_s;
  logic [ACC_W-1:0]       acc_base_s;
  logic [ACC_W-1:0]       sum_s;
  logic [ACC_W-1:0]       acc_next_s;
  logic                   cpu_hit_s;
  logic [PIX_W-1:0]       pix_next_s;
  logic                   pix_hit_s;

  assign locked_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous PLL lock flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Next-step values for the fractional accumulator and pixel divider
  always_comb begin
    acc_base_s = '0;
    sum_s      = '0;
    acc_next_s = '0;
    cpu_hit_s  = 1'b0;
    pix_next_s = '0;
    pix_hit_s  = 1'b0;
    // The step taken on the RUN entry edge starts from a zeroed accumulator
    if (state_r == ST_RUN) begin
      acc_base_s = acc_r;
    end else begin
      acc_base_s = '0;
    end
    sum_s = acc_base_s + ACC_NUM;
    if (sum_s >= ACC_DEN) begin
      acc_next_s = sum_s - ACC_DEN;
      cpu_hit_s  = 1'b1;
    end else begin
      acc_next_s = sum_s;
      cpu_hit_s  = 1'b0;
    end
    if (pix_cnt_r == PIX_LAST) begin
      pix_next_s = '0;
    end else begin
      pix_next_s = pix_cnt_r + PIX_W'(1);
    end
    pix_hit_s = (pix_cnt_r == PIX_PRE);
  end

  // Sequencer state machine with registered reset/ready/enable outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_WAIT_LOCK;
      hold_cnt_r <= '0;
      pix_cnt_r  <= '0;
      acc_r      <= '0;
      core_reset <= 1'b1;
      ready      <= 1'b0;
      ce_pix     <= 1'b0;
      ce_cpu     <= 1'b0;
    end else begin
      hold_cnt_r <= '0;
      pix_cnt_r  <= '0;
      acc_r      <= '0;
      core_reset <= 1'b1;
      ready      <= 1'b0;
      ce_pix     <= 1'b0;
      ce_cpu     <= 1'b0;
      case (state_r)
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_r <= ST_HOLD;
          end else begin
            state_r <= ST_WAIT_LOCK;
          end
        end
        ST_HOLD: begin
          if (!locked_s) begin
            state_r <= ST_WAIT_LOCK;
          end else if (hold_cnt_r == HOLD_LAST) begin
            state_r    <= ST_RUN;
            core_reset <= 1'b0;
            ready      <= 1'b1;
            acc_r      <= acc_next_s;
            ce_cpu     <= cpu_hit_s;
          end else begin
            state_r    <= ST_HOLD;
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_r <= ST_WAIT_LOCK;
          end else begin
            state_r    <= ST_RUN;
            core_reset <= 1'b0;
            ready      <= 1'b1;
            pix_cnt_r  <= pix_next_s;
            ce_pix     <= pix_hit_s;
            acc_r      <= acc_next_s;
            ce_cpu     <= cpu_hit_s;
          end
        end
        default: begin
          state_r <= ST_WAIT_LOCK;
        end
      endcase
    end
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  // Saturating count of lock losses seen while running
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_loss_cnt <= 8'd0;
    end else if ((state_r == ST_RUN) && !locked_s && (lock_loss_cnt != 8'd255)) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end else begin
      lock_loss_cnt <= lock_loss_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Directed self-checking bench for pll_reset_ce_gen (HOLD_CYCLES=16, plus a CE_NUM=CE_DEN=5 instance).
module tb_pll_reset_ce_gen;

  logic clk = 1'b0;
  logic rst;
  logic pll_locked;
  logic core_reset, ready, ce_pix, ce_cpu;
  logic core_reset2, ready2, ce_pix2, ce_cpu2;
`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt, lock_loss_cnt2;
`endif

  int checks = 0;
  int errors = 0;
  int n_pix, n_cpu, f_pix, f_cpu;

  always #5 clk = ~clk;

  pll_reset_ce_gen #(.SYNC_STAGES(2), .HOLD_CYCLES(16), .DIV_PIX(8), .CE_NUM(8), .CE_DEN(125)) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .core_reset(core_reset), .ready(ready), .ce_pix(ce_pix),
`ifdef PLL_LOCK_LOSS_CNT_EN
    .lock_loss_cnt(lock_loss_cnt),
`endif
    .ce_cpu(ce_cpu)
  );

  pll_reset_ce_gen #(.SYNC_STAGES(2), .HOLD_CYCLES(16), .DIV_PIX(8), .CE_NUM(5), .CE_DEN(5)) dut2 (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .core_reset(core_reset2), .ready(ready2), .ce_pix(ce_pix2),
`ifdef PLL_LOCK_LOSS_CNT_EN
    .lock_loss_cnt(lock_loss_cnt2),
`endif
    .ce_cpu(ce_cpu2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then park on the falling edge for sampling/driving.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_core_reset"}, core_reset, 1);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_ce_pix"}, ce_pix, 0);
    check({tag, "_ce_cpu"}, ce_cpu, 0);
    check({tag, "_ce_cpu2"}, ce_cpu2, 0);
  endtask

  // Expect 18 edges still in reset, release on the 19th.
  task automatic expect_release(input string tag);
    for (int e = 1; e <= 18; e++) begin
      step(1);
      check({tag, "_held"}, core_reset, 1);
      check({tag, "_held_ready"}, ready, 0);
    end
    step(1);
    check({tag, "_released"}, core_reset, 0);
    check({tag, "_ready"}, ready, 1);
  endtask

  // Walk RUN cycles 1..n (cycle 1 is the current sample) against the ratio model.
  task automatic run_cycles(input string tag, input int n,
                            output int pix_tot, output int cpu_tot,
                            output int first_pix, output int first_cpu);
    int win;
    logic exp_pix, exp_cpu;
    pix_tot = 0; cpu_tot = 0; first_pix = 0; first_cpu = 0; win = 0;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) step(1);
      exp_pix = ((c % 8) == 0);
      exp_cpu = (((8 * c) / 125) != ((8 * (c - 1)) / 125));
      check({tag, "_ce_pix"}, ce_pix, exp_pix);
      check({tag, "_ce_cpu"}, ce_cpu, exp_cpu);
      check({tag, "_ready"}, ready, 1);
      check({tag, "_ce_cpu_full_ratio"}, ce_cpu2, 1);
      if (ce_pix === 1'b1) begin
        pix_tot++;
        if (first_pix == 0) first_pix = c;
      end
      if (ce_cpu === 1'b1) begin
        cpu_tot++;
        win++;
        if (first_cpu == 0) first_cpu = c;
      end
      if ((c % 125) == 0) begin
        check({tag, "_cpu_window"}, win, 8);
        win = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    step(4);
    check_idle("reset");
`ifdef PLL_LOCK_LOSS_CNT_EN
    check("reset_loss_cnt", lock_loss_cnt, 0);
`endif

    // Clean release and 1000 RUN cycles
    rst = 1'b0;
    pll_locked = 1'b1;
    expect_release("release");
    run_cycles("run", 1000, n_pix, n_cpu, f_pix, f_cpu);
    check("run_pix_total", n_pix, 125);
    check("run_cpu_total", n_cpu, 64);
    check("run_first_pix", f_pix, 8);
    check("run_first_cpu", f_cpu, 16);

    // Lock loss in RUN
    pll_locked = 1'b0;
    step(2);
    check("loss_edge2_core_reset", core_reset, 0);
    step(1);
    check_idle("loss_edge3");
`ifdef PLL_LOCK_LOSS_CNT_EN
    check("loss_cnt_one", lock_loss_cnt, 1);
`endif

    // Restore: phases restart
    pll_locked = 1'b1;
    expect_release("rerelease");
    run_cycles("rerun", 16, n_pix, n_cpu, f_pix, f_cpu);
    check("rerun_first_pix", f_pix, 8);
    check("rerun_first_cpu", f_cpu, 16);
    check("rerun_pix_total", n_pix, 2);
    check("rerun_cpu_total", n_cpu, 1);

    // Synchronous reset mid-RUN with lock held
    rst = 1'b1;
    step(1);
    check_idle("rst_mid");
`ifdef PLL_LOCK_LOSS_CNT_EN
    check("rst_mid_loss_cnt", lock_loss_cnt, 0);
`endif
    rst = 1'b0;
    expect_release("rst_release");

    // Hold abort: 10 high, 3 low, then high again
    pll_locked = 1'b0;
    step(3);
    check_idle("drop2");
    pll_locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("abort_high_held", core_reset, 1);
    end
    pll_locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("abort_low_held", core_reset, 1);
    end
    pll_locked = 1'b1;
    expect_release("abort");
`ifdef PLL_LOCK_LOSS_CNT_EN
    check("abort_not_counted", lock_loss_cnt, 1);
    for (int k = 0; k < 299; k++) begin
      pll_locked = 1'b0;
      step(3);
      pll_locked = 1'b1;
      step(19);
      if (k == 9) check("loss_cnt_eleven", lock_loss_cnt, 11);
    end
    check("loss_cnt_running", core_reset, 0);
    check("loss_cnt_saturated", lock_loss_cnt, 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
